// File: rtl/ifu_pkg.sv
// Shared core package: fetch FSM state encoding and the canonical NOP
// that stands in for faulted fetches.
package ifu_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } ifu_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding bus fetcher with a one-entry
// hold buffer towards decode and redirect handling from execute.
module ifu #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ibus_req_valid,
    input  logic            ibus_req_ready,
    output logic [XLEN-1:0] ibus_req_addr,
    input  logic            ibus_rsp_valid,
    input  logic [XLEN-1:0] ibus_rsp_data,
    input  logic            ibus_rsp_err,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc,
    output logic            if_fault,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);
    import ifu_pkg::*;

    localparam logic [XLEN-1:0] W_NOP = XLEN'(NOP_INST);

    ifu_state_t      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_hold_inst;
    logic [XLEN-1:0] r_hold_pc;
    logic            r_hold_fault;
    logic            r_drop;

    ifu_state_t      w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_hold_inst_nxt;
    logic [XLEN-1:0] w_hold_pc_nxt;
    logic            w_hold_fault_nxt;
    logic            w_drop_nxt;
    logic            w_rsp;
    logic            w_misalign;
    logic            w_inflight;

    // A response that arrives while r_drop is set belongs to an abandoned fetch.
    assign w_rsp      = ibus_rsp_valid & ~r_drop;
    assign w_misalign = redirect_valid & (|redirect_pc[1:0]);
    assign w_inflight = ((r_state == REQ) & ibus_req_ready) |
                        (((r_state == WAIT) | (r_state == DROP)) & ~w_rsp);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_hold_inst_nxt  = r_hold_inst;
        w_hold_pc_nxt    = r_hold_pc;
        w_hold_fault_nxt = r_hold_fault;
        w_drop_nxt       = r_drop;

        if (ibus_rsp_valid && r_drop) begin
            w_drop_nxt = 1'b0;
        end

        if (w_misalign) begin
            w_state_nxt      = HOLD;
            w_pc_nxt         = redirect_pc;
            w_hold_inst_nxt  = W_NOP;
            w_hold_pc_nxt    = redirect_pc;
            w_hold_fault_nxt = 1'b1;
            if (w_inflight) begin
                w_drop_nxt = 1'b1;
            end
        end else if (redirect_valid) begin
            w_pc_nxt = redirect_pc;
            case (r_state)
                REQ:     w_state_nxt = ibus_req_ready ? DROP : REQ;
                WAIT:    w_state_nxt = w_rsp ? REQ : DROP;
                HOLD:    w_state_nxt = REQ;
                DROP:    w_state_nxt = w_rsp ? REQ : DROP;
                default: w_state_nxt = REQ;
            endcase
        end else begin
            case (r_state)
                REQ: begin
                    if (ibus_req_ready) w_state_nxt = WAIT;
                end
                WAIT: begin
                    if (w_rsp) begin
                        w_state_nxt      = HOLD;
                        w_hold_inst_nxt  = ibus_rsp_err ? W_NOP : ibus_rsp_data;
                        w_hold_pc_nxt    = r_pc;
                        w_hold_fault_nxt = ibus_rsp_err;
                    end
                end
                HOLD: begin
                    if (if_ready) begin
                        w_state_nxt = REQ;
                        w_pc_nxt    = r_pc + XLEN'(4);
                    end
                end
                DROP: begin
                    if (w_rsp) w_state_nxt = REQ;
                end
                default: w_state_nxt = REQ;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= REQ;
            r_pc         <= PC_RESET;
            r_hold_inst  <= '0;
            r_hold_pc    <= '0;
            r_hold_fault <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_hold_inst  <= w_hold_inst_nxt;
            r_hold_pc    <= w_hold_pc_nxt;
            r_hold_fault <= w_hold_fault_nxt;
            r_drop       <= w_drop_nxt;
        end
    end

    assign ibus_req_valid = (r_state == REQ) & ~rst;
    assign ibus_req_addr  = r_pc;
    assign if_valid       = (r_state == HOLD) & ~rst;
    assign if_inst        = r_hold_inst;
    assign if_pc          = r_hold_pc;
    assign if_fault       = r_hold_fault;

endmodule
